// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: FSM encoding and
// address-field width helpers.
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StWrite = 2'd2
  } state_e;

  // Word-offset field width inside a line.
  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  // Line-index field width.
  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Tag width: whatever remains above index, offset and the byte bits.
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines,
                                        input int unsigned words);
    return addr_w - idx_w(lines) - off_w(words) - 2;
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid bits and tags for the direct-mapped cache. Combinational lookup,
// one write port, and a whole-array invalidate that wins over a write.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned TAG_W = 26
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [idx_w(LINES)-1:0]  lookup_idx,
  output logic                     lookup_valid,
  output logic [TAG_W-1:0]         lookup_tag,
  input  logic                     wr_en,
  input  logic [idx_w(LINES)-1:0]  wr_idx,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic                     inv_all
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  // Valid bits: invalidate beats a simultaneous line install.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag storage is not reset; validity alone qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  assign lookup_valid = valid_q[lookup_idx];
  assign lookup_tag   = tag_q[lookup_idx];

endmodule

// File: rtl/dcache_dm.sv
// Blocking direct-mapped write-through, no-write-allocate data cache.
// Read hits complete in the same cycle; misses fill a whole line over a
// req/ack handshake, and every store waits for the memory ack.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  input  logic              inv_all,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned OFF_W  = off_w(WORDS);
  localparam int unsigned OFF_WS = (OFF_W > 0) ? OFF_W : 1;  // keeps counters non-empty
  localparam int unsigned IDX_W  = idx_w(LINES);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, LINES, WORDS);

  // Address split (pipeline holds cpu_addr stable while stalled).
  logic [OFF_WS-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  assign off = (OFF_W == 0) ? '0 : OFF_WS'(cpu_addr >> 2);
  assign idx = IDX_W'(cpu_addr >> (2 + OFF_W));
  assign tag = TAG_W'(cpu_addr >> (2 + OFF_W + IDX_W));

  state_e            state_q, state_d;
  logic [OFF_WS-1:0] fill_cnt_q, fill_cnt_d;
  logic              inv_pend_q, inv_pend_d;
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic              line_match, rd_hit, fill_last;
  logic              tag_wr, tag_clr, data_fill_we, data_wr_we, cnt_hit, cnt_miss;
  logic [ADDR_W-1:0] word_addr, fill_addr;

  dcache_tag_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk          (clk),
    .reset        (reset),
    .lookup_idx   (idx),
    .lookup_valid (line_valid),
    .lookup_tag   (line_tag),
    .wr_en        (tag_wr),
    .wr_idx       (idx),
    .wr_tag       (tag),
    .inv_all      (tag_clr)
  );

  assign line_match = line_valid && (line_tag == tag);
  // An invalidate in the same cycle turns a would-be hit into a miss.
  assign rd_hit     = line_match && !inv_all;
  assign fill_last  = (fill_cnt_q == OFF_WS'(WORDS - 1));
  assign word_addr  = cpu_addr & ~ADDR_W'(3);
  assign fill_addr  = (cpu_addr & ~ADDR_W'(WORDS * 4 - 1)) | (ADDR_W'(fill_cnt_q) << 2);

  // FSM, fill counter and deferred-invalidate flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fill_cnt_q <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  // Statistics counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (cnt_hit)  hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (cnt_miss) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  // Line data: fill words from memory, or patch a resident word on a store.
  always_ff @(posedge clk) begin
    if (data_fill_we) begin
      data_q[idx][fill_cnt_q] <= mem_rdata;
    end else if (data_wr_we) begin
      data_q[idx][off] <= cpu_wdata;
    end
  end

  // Next-state, handshake outputs and array/counter strobes.
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    inv_pend_d   = inv_pend_q;
    tag_wr       = 1'b0;
    tag_clr      = 1'b0;
    data_fill_we = 1'b0;
    data_wr_we   = 1'b0;
    cnt_hit      = 1'b0;
    cnt_miss     = 1'b0;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = word_addr;
    mem_wdata    = cpu_wdata;
    // Reset aborts any transaction immediately; nothing is driven or written.
    if (!reset) begin
      case (state_q)
        StIdle: begin
          tag_clr = inv_all;
          if (cpu_wr) begin
            stall   = 1'b1;
            state_d = StWrite;
          end else if (cpu_rd) begin
            if (rd_hit) begin
              cnt_hit = 1'b1;
            end else begin
              stall      = 1'b1;
              cnt_miss   = 1'b1;
              fill_cnt_d = '0;
              state_d    = StFill;
            end
          end
        end
        StFill: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = fill_addr;
          if (inv_all) inv_pend_d = 1'b1;
          if (mem_ack) begin
            data_fill_we = 1'b1;
            fill_cnt_d   = fill_cnt_q + 1'b1;
            if (fill_last) begin
              tag_wr     = 1'b1;
              // A deferred invalidate also drops the line just installed.
              tag_clr    = inv_pend_q || inv_all;
              inv_pend_d = 1'b0;
              state_d    = StIdle;
            end
          end
        end
        StWrite: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          stall   = !mem_ack;
          if (inv_all) inv_pend_d = 1'b1;
          if (mem_ack) begin
            data_wr_we = line_match;
            tag_clr    = inv_pend_q || inv_all;
            inv_pend_d = 1'b0;
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign cpu_rdata = reset ? '0 : data_q[idx][off];
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: a table of single accesses with hand-computed
// results, plus sequences for reset during a fill and memory side effects.
module tb_dcache_dm;

  logic        clk = 1'b0;
  logic        reset, cpu_rd, cpu_wr, inv_all, stall, mem_req, mem_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_dm #(
    .ADDR_W (32),
    .DATA_W (32),
    .LINES  (16),
    .WORDS  (4),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .inv_all   (inv_all),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  // Backing memory: word i initially holds 0x1000_0000 + i.
  logic [31:0] bmem [0:1023];
  int          wait_cnt;

  // Memory responder: ack arrives 2 cycles after each request begins.
  initial begin
    for (int i = 0; i < 1024; i++) bmem[i] = 32'h1000_0000 + 32'(i);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
      if (!mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt == 2) begin
        mem_ack = 1'b1;
        if (mem_we) bmem[mem_addr[11:2]] = mem_wdata;
        else        mem_rdata = bmem[mem_addr[11:2]];
      end else begin
        wait_cnt++;
      end
    end
  end

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          inv_at;     // cycle of the access in which inv_all pulses, -1 none
    logic [31:0] exp_rdata;
    int          exp_stalls;
    int          exp_nreq;
    logic [31:0] exp_addr0;  // first mem_addr while mem_req is high
    logic        exp_we;
    int          exp_hit;
    int          exp_miss;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          r_stalls, r_nreq;
  logic [31:0] r_rdata, r_addr0;
  logic        r_we;
  logic [31:0] ack_addrs [$];
  vec_t        vt [16];

  function automatic vec_t mk(input string n, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd, input int inv_at,
                              input logic [31:0] erd, input int est, input int enr,
                              input logic [31:0] ea0, input logic ewe, input int eh,
                              input int em);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.inv_at = inv_at;
    v.exp_rdata = erd; v.exp_stalls = est; v.exp_nreq = enr; v.exp_addr0 = ea0;
    v.exp_we = ewe; v.exp_hit = eh; v.exp_miss = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one access and hold it until stall drops; entered at posedge+2.
  task automatic run_access(input vec_t v);
    int cyc = 0;
    cpu_rd    = v.rd;
    cpu_wr    = v.wr;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    inv_all   = (v.inv_at == 0);
    r_stalls  = 0;
    r_nreq    = 0;
    r_we      = 1'b0;
    r_addr0   = '0;
    ack_addrs.delete();
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (r_nreq == 0) r_addr0 = mem_addr;
        r_nreq++;
        if (mem_we) r_we = 1'b1;
        if (mem_ack) ack_addrs.push_back(mem_addr);
      end
      if (!stall) begin
        r_rdata = cpu_rdata;
        break;
      end
      r_stalls++;
      @(posedge clk);
      #2;
      cyc++;
      inv_all = (cyc == v.inv_at);
      if (cyc > 300) begin
        total++;
        bad++;
        $display("FAIL %s.timeout: stall still high after %0d cycles, required low", v.name,
                 cyc);
        break;
      end
    end
    @(posedge clk);
    #2;
    cpu_rd  = 1'b0;
    cpu_wr  = 1'b0;
    inv_all = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    run_access(v);
    if (v.rd && !v.wr) check({v.name, ".rdata"}, r_rdata, v.exp_rdata);
    check({v.name, ".stalls"}, 32'(r_stalls), 32'(v.exp_stalls));
    check({v.name, ".nreq"}, 32'(r_nreq), 32'(v.exp_nreq));
    if (v.exp_nreq > 0) check({v.name, ".addr0"}, r_addr0, v.exp_addr0);
    check({v.name, ".we"}, 32'(r_we), 32'(v.exp_we));
    check({v.name, ".hit_cnt"}, 32'(hit_cnt), 32'(v.exp_hit));
    check({v.name, ".miss_cnt"}, 32'(miss_cnt), 32'(v.exp_miss));
  endtask

  task automatic check_fill_seq(input string name, input logic [31:0] base);
    check({name, ".nacks"}, 32'(ack_addrs.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < ack_addrs.size()) check({name, ".fill_addr"}, ack_addrs[j], base + 32'(4 * j));
    end
  endtask

  initial begin
    int   nacks;
    vec_t v;
    //          name               rd wr addr        wdata         inv rdata         st  nr addr0  we h  m
    vt[0]  = mk("cold_rd_40",      1, 0, 32'h40,  32'h0,          -1, 32'h1000_0010, 13, 12, 32'h40, 0, 1, 1);
    vt[1]  = mk("hit_rd_44",       1, 0, 32'h44,  32'h0,          -1, 32'h1000_0011, 0,  0,  32'h0,  0, 2, 1);
    vt[2]  = mk("conflict_rd_140", 1, 0, 32'h140, 32'h0,          -1, 32'h1000_0050, 13, 12, 32'h140, 0, 3, 2);
    vt[3]  = mk("reread_rd_40",    1, 0, 32'h40,  32'h0,          -1, 32'h1000_0010, 13, 12, 32'h40, 0, 4, 3);
    vt[4]  = mk("wr_hit_48",       0, 1, 32'h48,  32'hDEAD_BEEF,  -1, 32'h0,         3,  3,  32'h48, 1, 4, 3);
    vt[5]  = mk("rd_48",           1, 0, 32'h48,  32'h0,          -1, 32'hDEAD_BEEF, 0,  0,  32'h0,  0, 5, 3);
    vt[6]  = mk("wr_miss_200",     0, 1, 32'h200, 32'h1234_5678,  -1, 32'h0,         3,  3,  32'h200, 1, 5, 3);
    vt[7]  = mk("rd_200",          1, 0, 32'h200, 32'h0,          -1, 32'h1234_5678, 13, 12, 32'h200, 0, 6, 4);
    vt[8]  = mk("inv_only",        0, 0, 32'h0,   32'h0,           0, 32'h0,         0,  0,  32'h0,  0, 6, 4);
    vt[9]  = mk("rd_44_after_inv", 1, 0, 32'h44,  32'h0,          -1, 32'h1000_0011, 13, 12, 32'h40, 0, 7, 5);
    vt[10] = mk("inv_with_rd_44",  1, 0, 32'h44,  32'h0,           0, 32'h1000_0011, 13, 12, 32'h40, 0, 8, 6);
    vt[11] = mk("rd_200_after_inv",1, 0, 32'h200, 32'h0,          -1, 32'h1234_5678, 13, 12, 32'h200, 0, 9, 7);
    vt[12] = mk("wr_rd_both_44",   1, 1, 32'h44,  32'hCAFE_F00D,  -1, 32'h0,         3,  3,  32'h44, 1, 9, 7);
    vt[13] = mk("rd_44_updated",   1, 0, 32'h44,  32'h0,          -1, 32'hCAFE_F00D, 0,  0,  32'h0,  0, 10, 7);
    vt[14] = mk("inv_mid_fill_80", 1, 0, 32'h80,  32'h0,           5, 32'h1000_0020, 26, 24, 32'h80, 0, 11, 9);
    vt[15] = mk("rd_80_hit",       1, 0, 32'h80,  32'h0,          -1, 32'h1000_0020, 0,  0,  32'h0,  0, 12, 9);

    // Reset with a load pending: stall and load data must stay low.
    reset     = 1'b1;
    cpu_rd    = 1'b1;
    cpu_wr    = 1'b0;
    cpu_addr  = 32'h40;
    cpu_wdata = '0;
    inv_all   = 1'b0;
    @(negedge clk);
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.rdata", cpu_rdata, 32'h0);
    check("reset.mem_req", 32'(mem_req), 32'd0);
    check("reset.mem_we", 32'(mem_we), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.hit_cnt", 32'(hit_cnt), 32'd0);
    check("reset.miss_cnt", 32'(miss_cnt), 32'd0);
    @(posedge clk);
    #2;
    reset  = 1'b0;
    cpu_rd = 1'b0;
    @(posedge clk);
    #2;

    for (int i = 0; i < 16; i++) begin
      check_vec(vt[i]);
      if (i == 0) check_fill_seq("cold_rd_40", 32'h40);
    end

    // Write-through side effects in backing memory.
    check("bmem_48", bmem[32'h12], 32'hDEAD_BEEF);
    check("bmem_200", bmem[32'h80], 32'h1234_5678);
    check("bmem_44", bmem[32'h11], 32'hCAFE_F00D);

    // Reset while filling word 2 of line 0xC0.
    cpu_rd   = 1'b1;
    cpu_addr = 32'hC0;
    nacks    = 0;
    for (int c = 0; c < 100 && nacks < 2; c++) begin
      @(negedge clk);
      if (mem_req && mem_ack) nacks++;
      @(posedge clk);
      #2;
    end
    check("rst_fill.acks_before_reset", 32'(nacks), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_fill.mem_req_in_reset", 32'(mem_req), 32'd0);
    check("rst_fill.stall_in_reset", 32'(stall), 32'd0);
    @(posedge clk);
    #2;
    reset  = 1'b0;
    cpu_rd = 1'b0;
    @(negedge clk);
    check("rst_fill.mem_req_after", 32'(mem_req), 32'd0);
    check("rst_fill.stall_after", 32'(stall), 32'd0);
    check("rst_fill.hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_fill.miss_cnt", 32'(miss_cnt), 32'd0);
    @(posedge clk);
    #2;
    v = mk("rst_refill_c0", 1, 0, 32'hC0, 32'h0, -1, 32'h1000_0030, 13, 12, 32'hC0, 0, 1, 1);
    check_vec(v);
    check_fill_seq("rst_refill_c0", 32'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
